// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: load-use interlock, redirect squash
// and a bounded wait on slow data memory, driving per-stage stall/flush controls.
module pipe_hazard_ctrl #(
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned WAIT_MAX     = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_ltype,
    input  logic        ex_regwrite,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        dm_ready,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        stall_mem,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        flush_wb,
    output logic        mem_err,
    output logic [31:0] stall_cycles
);

    localparam int unsigned BUBBLE_W = 2;
    localparam int unsigned WAIT_W   = 8;
    localparam int unsigned STATE_W  = 2;

    localparam logic [STATE_W-1:0] ST_RUN     = 2'd0;
    localparam logic [STATE_W-1:0] ST_LDSTALL = 2'd1;
    localparam logic [STATE_W-1:0] ST_MEMWAIT = 2'd2;

    logic [STATE_W-1:0]  state;
    logic [STATE_W-1:0]  state_nxt;
    logic [BUBBLE_W-1:0] bubble_cnt;
    logic [BUBBLE_W-1:0] bubble_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_nxt;
    logic                err_set;

    logic hazard;
    logic memwait;
    logic timeout;
    logic freeze;

    logic stall_if_raw;
    logic stall_id_raw;
    logic stall_ex_raw;
    logic stall_mem_raw;
    logic flush_id_raw;
    logic flush_ex_raw;
    logic flush_wb_raw;

    // Hazard and memory-wait qualifiers; x0 never creates a dependency
    always_comb begin
        hazard = ex_ltype && ex_regwrite && (ex_rd != 5'd0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd)));
        memwait = mem_req && !dm_ready;
        timeout = memwait && (wait_cnt == WAIT_W'(WAIT_MAX - 1));
        freeze  = memwait && !timeout;
    end

    // Next-state and stall/flush decode; a timed-out wait lets the instruction through once
    always_comb begin
        state_nxt     = state;
        bubble_nxt    = bubble_cnt;
        wait_nxt      = '0;
        err_set       = 1'b0;
        stall_if_raw  = 1'b0;
        stall_id_raw  = 1'b0;
        stall_ex_raw  = 1'b0;
        stall_mem_raw = 1'b0;
        flush_id_raw  = 1'b0;
        flush_ex_raw  = 1'b0;
        flush_wb_raw  = 1'b0;

        if (freeze) begin
            stall_if_raw  = 1'b1;
            stall_id_raw  = 1'b1;
            stall_ex_raw  = 1'b1;
            stall_mem_raw = 1'b1;
            flush_wb_raw  = 1'b1;
            state_nxt     = ST_MEMWAIT;
            wait_nxt      = wait_cnt + WAIT_W'(1);
            bubble_nxt    = '0;
        end else begin
            err_set = timeout;
            if (ex_redirect) begin
                flush_id_raw = 1'b1;
                flush_ex_raw = 1'b1;
                state_nxt    = ST_RUN;
                bubble_nxt   = '0;
            end else begin
                case (state)
                    ST_LDSTALL: begin
                        stall_if_raw = 1'b1;
                        stall_id_raw = 1'b1;
                        flush_ex_raw = 1'b1;
                        bubble_nxt   = bubble_cnt - BUBBLE_W'(1);
                        state_nxt    = (bubble_cnt == BUBBLE_W'(1)) ? ST_RUN : ST_LDSTALL;
                    end
                    default: begin
                        state_nxt = ST_RUN;
                        if (hazard) begin
                            stall_if_raw = 1'b1;
                            stall_id_raw = 1'b1;
                            flush_ex_raw = 1'b1;
                            if (LOAD_BUBBLES > 1) begin
                                state_nxt  = ST_LDSTALL;
                                bubble_nxt = BUBBLE_W'(LOAD_BUBBLES - 1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Controls are forced quiet while reset is asserted
    assign stall_if  = rstn & stall_if_raw;
    assign stall_id  = rstn & stall_id_raw;
    assign stall_ex  = rstn & stall_ex_raw;
    assign stall_mem = rstn & stall_mem_raw;
    assign flush_id  = rstn & flush_id_raw;
    assign flush_ex  = rstn & flush_ex_raw;
    assign flush_wb  = rstn & flush_wb_raw;

    // State, counters and sticky error
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= ST_RUN;
            bubble_cnt   <= '0;
            wait_cnt     <= '0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state      <= state_nxt;
            bubble_cnt <= bubble_nxt;
            wait_cnt   <= wait_nxt;
            if (err_set) begin
                mem_err <= 1'b1;
            end
            if (stall_if_raw) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl: two instances (1 and 2 load bubbles) checked every
// cycle against a counter-based reference model, plus directed literal expectations.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_ltype, ex_regwrite, ex_redirect, mem_req, dm_ready;

    logic        sif_a, sid_a, sex_a, smem_a, fid_a, fex_a, fwb_a, err_a;
    logic        sif_b, sid_b, sex_b, smem_b, fid_b, fex_b, fwb_b, err_b;
    logic [31:0] sc_a, sc_b;
    logic [6:0]  out_a, out_b;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_BUBBLES(1), .WAIT_MAX(15)) u_a (
        .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_ltype(ex_ltype), .ex_regwrite(ex_regwrite), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .dm_ready(dm_ready),
        .stall_if(sif_a), .stall_id(sid_a), .stall_ex(sex_a), .stall_mem(smem_a),
        .flush_id(fid_a), .flush_ex(fex_a), .flush_wb(fwb_a),
        .mem_err(err_a), .stall_cycles(sc_a));

    pipe_hazard_ctrl #(.LOAD_BUBBLES(2), .WAIT_MAX(5)) u_b (
        .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_ltype(ex_ltype), .ex_regwrite(ex_regwrite), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .dm_ready(dm_ready),
        .stall_if(sif_b), .stall_id(sid_b), .stall_ex(sex_b), .stall_mem(smem_b),
        .flush_id(fid_b), .flush_ex(fex_b), .flush_wb(fwb_b),
        .mem_err(err_b), .stall_cycles(sc_b));

    // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb}
    assign out_a = {sif_a, sid_a, sex_a, smem_a, fid_a, fex_a, fwb_a};
    assign out_b = {sif_b, sid_b, sex_b, smem_b, fid_b, fex_b, fwb_b};

    localparam logic [6:0] O_NONE   = 7'b0000000;
    localparam logic [6:0] O_FREEZE = 7'b1111001;
    localparam logic [6:0] O_BUBBLE = 7'b1100010;
    localparam logic [6:0] O_SQUASH = 7'b0000110;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Reference model: bubbles still owed, length of the current wait, error flag, stall count
    int          lb[2] = '{1, 2};
    int          wm[2] = '{15, 5};
    int          owed[2];
    int          waited[2];
    int          err_m[2];
    int unsigned stalls_m[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            owed[i] = 0; waited[i] = 0; err_m[i] = 0; stalls_m[i] = 0;
        end
    end

    function automatic bit dependent();
        bit r1, r2;
        r1 = id_use_rs1 && (id_rs1 == ex_rd);
        r2 = id_use_rs2 && (id_rs2 == ex_rd);
        return ex_ltype && ex_regwrite && (ex_rd != 0) && (r1 || r2);
    endfunction

    // Compare process: mid-cycle, inputs settled since the last rising edge
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [6:0]  e;
            logic [6:0]  g;
            logic        gerr;
            logic [31:0] gsc;
            bit          mw;
            g    = (i == 0) ? out_a : out_b;
            gerr = (i == 0) ? err_a : err_b;
            gsc  = (i == 0) ? sc_a : sc_b;
            e    = O_NONE;
            chk((i == 0) ? "mem_err_a" : "mem_err_b", 32'(gerr), 32'(err_m[i]));
            chk((i == 0) ? "stall_cycles_a" : "stall_cycles_b", gsc, stalls_m[i]);
            if (rstn !== 1'b1) begin
                owed[i] = 0; waited[i] = 0; err_m[i] = 0; stalls_m[i] = 0;
            end else begin
                mw = mem_req && !dm_ready;
                if (mw && waited[i] < wm[i] - 1) begin
                    e = O_FREEZE;
                    waited[i]++;
                    owed[i] = 0;
                end else begin
                    if (mw) err_m[i] = 1;
                    waited[i] = 0;
                    if (ex_redirect) begin
                        e = O_SQUASH;
                        owed[i] = 0;
                    end else if (owed[i] > 0) begin
                        e = O_BUBBLE;
                        owed[i]--;
                    end else if (dependent()) begin
                        e = O_BUBBLE;
                        owed[i] = lb[i] - 1;
                    end
                end
                if (e[6]) stalls_m[i]++;
            end
            chk((i == 0) ? "ctrl_a" : "ctrl_b", 32'(g), 32'(e));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_ltype = 1'b0; ex_regwrite = 1'b0; ex_redirect = 1'b0;
        mem_req = 1'b0; dm_ready = 1'b1;
    endtask

    // lw x5 in EX, add x6,x5,x7 in ID
    task automatic load_use();
        ex_rd = 5'd5; ex_ltype = 1'b1; ex_regwrite = 1'b1;
        id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    endtask

    int burst;

    initial begin
        rstn = 1'b0;
        idle();
        load_use();
        #2;
        chk("rst_quiet_a", 32'(out_a), 32'(O_NONE));
        cyc(); cyc();
        chk("rst_sc_a", sc_a, 32'd0);
        chk("rst_err_b", 32'(err_b), 32'd0);

        // load-use: one bubble on a, two on b
        rstn = 1'b1;
        #2;
        chk("lu1_a", 32'(out_a), 32'(O_BUBBLE));
        chk("lu1_b", 32'(out_b), 32'(O_BUBBLE));
        cyc();
        ex_ltype = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;
        #2;
        chk("lu2_a", 32'(out_a), 32'(O_NONE));
        chk("lu2_b", 32'(out_b), 32'(O_BUBBLE));
        cyc();
        #2;
        chk("lu3_b", 32'(out_b), 32'(O_NONE));
        chk("lu_sc_a", sc_a, 32'd1);
        chk("lu_sc_b", sc_b, 32'd2);

        // load-use together with a redirect: squash wins
        load_use(); ex_redirect = 1'b1;
        #2;
        chk("redir_a", 32'(out_a), 32'(O_SQUASH));
        chk("redir_b", 32'(out_b), 32'(O_SQUASH));
        cyc();
        idle();
        #2;
        chk("redir_after_b", 32'(out_b), 32'(O_NONE));
        cyc();

        // four-cycle memory wait, then completion
        mem_req = 1'b1; dm_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("mw_freeze_a", 32'(out_a), 32'(O_FREEZE));
            chk("mw_freeze_b", 32'(out_b), 32'(O_FREEZE));
            cyc();
        end
        dm_ready = 1'b1;
        #2;
        chk("mw_done_a", 32'(out_a), 32'(O_NONE));
        cyc();
        chk("mw_err_a", 32'(err_a), 32'd0);
        chk("mw_err_b", 32'(err_b), 32'd0);

        // memory never answers: 14 freeze cycles then one released cycle
        dm_ready = 1'b0;
        for (int k = 0; k < 14; k++) begin
            #2;
            chk("to_freeze_a", 32'(out_a), 32'(O_FREEZE));
            cyc();
        end
        #2;
        chk("to_release_a", 32'(out_a), 32'(O_NONE));
        cyc();
        chk("to_err_a", 32'(err_a), 32'd1);
        chk("to_err_b", 32'(err_b), 32'd1);
        idle();
        cyc(); cyc();
        chk("to_sticky_a", 32'(err_a), 32'd1);

        // reset in the middle of a load stall
        load_use();
        cyc();
        idle();
        rstn = 1'b0;
        #2;
        chk("rst_ld_quiet_b", 32'(out_b), 32'(O_NONE));
        cyc();
        rstn = 1'b1;
        #2;
        chk("rst_ld_out_b", 32'(out_b), 32'(O_NONE));
        chk("rst_ld_sc_b", sc_b, 32'd0);
        chk("rst_ld_err_a", 32'(err_a), 32'd0);
        cyc();

        // randomized traffic
        burst = 0;
        for (int n = 0; n < 4000; n++) begin
            rstn        = ($urandom_range(0, 199) != 0);
            ex_rd       = 5'($urandom_range(0, 3));
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            ex_ltype    = ($urandom_range(0, 2) != 0);
            ex_regwrite = ($urandom_range(0, 4) != 0);
            ex_redirect = ($urandom_range(0, 9) == 0);
            mem_req     = ($urandom_range(0, 9) < 3);
            if (burst == 0 && $urandom_range(0, 49) == 0) burst = $urandom_range(3, 20);
            if (burst > 0) begin
                mem_req  = 1'b1;
                dm_ready = 1'b0;
                burst--;
            end else begin
                dm_ready = ($urandom_range(0, 9) < 6);
            end
            cyc();
        end

        idle();
        cyc(); cyc();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
